// File: rtl/uart_cmd_frame_parser.sv
// Purpose: assembles 3-byte command frames (SYNC, ID, CHECK) from a UART byte
// stream, latches validated 6-bit command IDs for the display, and rejects or
// aborts malformed or stalled frames while counting them.
// Ports:
//   clk        in   rising-edge system clock
//   nRESET     in   asynchronous active-low reset
//   rx_data    in   received byte, sampled when rx_valid=1
//   rx_valid   in   one-cycle byte strobe
//   id_out     out  last validated command ID, held until next good frame
//   id_valid   out  one-cycle pulse when id_out updates
//   frame_err  out  one-cycle pulse on a rejected or aborted frame
//   err_count  out  saturating count of frame_err pulses
//   busy       out  high while a frame is partially received
module uart_cmd_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CYC  = 1000,
    parameter bit          REVERSE_BITS = 1'b1
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [5:0] id_out,
    output logic       id_valid,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ID  = 2'd1,
        ST_WAIT_CHK = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [5:0]       id_tmp_q, id_tmp_d;
    logic [5:0]       id_q, id_d;
    logic             id_valid_q, id_valid_d;
    logic             ferr_q, ferr_d;
    logic [7:0]       err_q, err_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0] b_rev;
    logic [7:0] b;

    // Byte path: optional bit reversal for LSB-first sources
    always_comb begin
        b_rev = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b_rev[i] = rx_data[7-i];
        end
        b = REVERSE_BITS ? b_rev : rx_data;
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        id_tmp_d   = id_tmp_q;
        id_d       = id_q;
        id_valid_d = 1'b0;
        ferr_d     = 1'b0;
        cnt_d      = cnt_q;

        if (rx_valid) begin
            // A byte always wins over a timeout expiring in the same cycle
            cnt_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (b == SYNC_BYTE) state_d = ST_WAIT_ID;
                end
                ST_WAIT_ID: begin
                    if (b[7:6] == 2'b00) begin
                        id_tmp_d = b[5:0];
                        state_d  = ST_WAIT_CHK;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = (b == SYNC_BYTE) ? ST_WAIT_ID : ST_IDLE;
                    end
                end
                ST_WAIT_CHK: begin
                    if (b == ~{2'b00, id_tmp_q}) begin
                        id_d       = id_tmp_q;
                        id_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = (b == SYNC_BYTE) ? ST_WAIT_ID : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        err_d  = (ferr_d && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= ST_IDLE;
            id_tmp_q   <= 6'h00;
            id_q       <= 6'h00;
            id_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            err_q      <= 8'h00;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            id_tmp_q   <= id_tmp_d;
            id_q       <= id_d;
            id_valid_q <= id_valid_d;
            ferr_q     <= ferr_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
        end
    end

    assign id_out    = id_q;
    assign id_valid  = id_valid_q;
    assign frame_err = ferr_q;
    assign err_count = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Directed bench: straight-order frames (dut0) and bit-reversed frames (dut1).
module tb_uart_cmd_frame_parser;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       nRESET = 1'b0;
    logic [7:0] rx_data0 = 8'h00, rx_data1 = 8'h00;
    logic       rx_valid0 = 1'b0, rx_valid1 = 1'b0;
    logic [5:0] id0, id1;
    logic       idv0, idv1, fe0, fe1, busy0, busy1;
    logic [7:0] ec0, ec1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_cmd_frame_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO), .REVERSE_BITS(1'b0)) dut0 (
        .clk(clk), .nRESET(nRESET), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .id_out(id0), .id_valid(idv0), .frame_err(fe0), .err_count(ec0), .busy(busy0)
    );

    uart_cmd_frame_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO), .REVERSE_BITS(1'b1)) dut1 (
        .clk(clk), .nRESET(nRESET), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .id_out(id1), .id_valid(idv1), .frame_err(fe1), .err_count(ec1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One-cycle strobe; returns at the negedge after the processing edge
    task automatic send(input bit sel, input logic [7:0] b);
        @(negedge clk);
        if (sel) begin rx_data1 = b; rx_valid1 = 1'b1; end
        else     begin rx_data0 = b; rx_valid0 = 1'b1; end
        @(negedge clk);
        rx_valid0 = 1'b0;
        rx_valid1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset
        idle(2);
        chk("rst_id0", 32'(id0), 0);
        chk("rst_idv0", 32'(idv0), 0);
        chk("rst_fe0", 32'(fe0), 0);
        chk("rst_ec0", 32'(ec0), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_id1", 32'(id1), 0);
        nRESET = 1'b1;
        idle(1);

        // 1: good frame
        send(0, 8'hA5);
        chk("t1_busy_after_sync", 32'(busy0), 1);
        send(0, 8'h05);
        chk("t1_idv_early", 32'(idv0), 0);
        send(0, 8'hFA);
        chk("t1_idv", 32'(idv0), 1);
        chk("t1_id", 32'(id0), 32'h05);
        chk("t1_ec", 32'(ec0), 0);
        chk("t1_busy_done", 32'(busy0), 0);
        idle(1);
        chk("t1_idv_pulse", 32'(idv0), 0);

        // Noise in IDLE is ignored
        send(0, 8'h33);
        chk("noise_fe", 32'(fe0), 0);
        chk("noise_busy", 32'(busy0), 0);

        // 2: bad check byte
        send(0, 8'hA5);
        send(0, 8'h05);
        send(0, 8'hFB);
        chk("t2_fe", 32'(fe0), 1);
        chk("t2_ec", 32'(ec0), 1);
        chk("t2_id", 32'(id0), 32'h05);
        chk("t2_idv", 32'(idv0), 0);
        idle(1);
        chk("t2_fe_pulse", 32'(fe0), 0);

        // 3: timeout after TO idle cycles
        send(0, 8'hA5);
        idle(TO - 1);
        chk("t3_busy_pre", 32'(busy0), 1);
        chk("t3_fe_pre", 32'(fe0), 0);
        idle(1);
        chk("t3_fe", 32'(fe0), 1);
        chk("t3_busy", 32'(busy0), 0);
        chk("t3_ec", 32'(ec0), 2);
        idle(1);
        chk("t3_fe_pulse", 32'(fe0), 0);
        // Byte on the expiry cycle wins
        send(0, 8'hA5);
        idle(TO - 2);
        send(0, 8'h2A);
        chk("t3_exp_fe", 32'(fe0), 0);
        chk("t3_exp_busy", 32'(busy0), 1);
        chk("t3_exp_ec", 32'(ec0), 2);
        send(0, 8'hD5);
        chk("t3_exp_idv", 32'(idv0), 1);
        chk("t3_exp_id", 32'(id0), 32'h2A);

        // 4: resync on SYNC in the ID slot
        send(0, 8'hA5);
        send(0, 8'hA5);
        chk("t4_fe", 32'(fe0), 1);
        chk("t4_busy", 32'(busy0), 1);
        chk("t4_ec", 32'(ec0), 3);
        send(0, 8'h05);
        send(0, 8'hFA);
        chk("t4_idv", 32'(idv0), 1);
        chk("t4_id", 32'(id0), 32'h05);
        chk("t4_ec_after", 32'(ec0), 3);

        // 5: bit-reversed source, then saturation
        send(1, 8'hA5);
        send(1, 8'hA0);
        send(1, 8'h5F);
        chk("t5_idv", 32'(idv1), 1);
        chk("t5_id", 32'(id1), 32'h05);
        chk("t5_ec0", 32'(ec1), 0);
        for (int i = 0; i < 300; i++) begin
            send(1, 8'hA5);
            send(1, 8'hFF);
            if (i == 253) chk("t5_ec_254", 32'(ec1), 32'hFE);
            if (i == 254) chk("t5_ec_255", 32'(ec1), 32'hFF);
        end
        chk("t5_fe_last", 32'(fe1), 1);
        chk("t5_ec_sat", 32'(ec1), 32'hFF);
        chk("t5_id_kept", 32'(id1), 32'h05);

        // 6: reset between ID and CHECK
        send(0, 8'hA5);
        send(0, 8'h07);
        nRESET = 1'b0;
        #1;
        chk("t6_id", 32'(id0), 0);
        chk("t6_ec", 32'(ec0), 0);
        chk("t6_busy", 32'(busy0), 0);
        chk("t6_fe", 32'(fe0), 0);
        chk("t6_ec1", 32'(ec1), 0);
        @(negedge clk);
        nRESET = 1'b1;
        send(0, 8'hF8);
        chk("t6_stray_chk", 32'(idv0), 0);
        send(0, 8'hA5);
        send(0, 8'h07);
        send(0, 8'hF8);
        chk("t6_idv", 32'(idv0), 1);
        chk("t6_id_new", 32'(id0), 32'h07);
        chk("t6_ec_new", 32'(ec0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
